// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder: sequences one output-group pass into conv_top.
// Pulls bias, weight and pixel words from one upstream valid/ready stream,
// pulses go, waits for conv_done, then flushes the line buffers with zero
// pixels and holds conv_rst before reporting done.
// Ports: clk/rst_n; start + cfg_* (latched on accept); s_data/s_valid/s_ready
// upstream; bias_wr_*, wt_wr_*, pixel_in* and go toward conv_top;
// conv_done from conv_top; conv_rst to conv_top; busy/done status.
module conv_stream_feeder #(
    parameter int S_W         = 128,
    parameter int BIAS_W      = 128,
    parameter int WT_W        = 72,
    parameter int PIX_W       = 64,
    parameter int CNT_W       = 24,
    parameter int CRST_CYCLES = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_n_bias,
    input  logic [CNT_W-1:0]  cfg_n_wt,
    input  logic [CNT_W-1:0]  cfg_n_pix,
    input  logic [15:0]       cfg_img_width,
    input  logic [15:0]       cfg_in_channels,
    input  logic [S_W-1:0]    s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              bias_wr_en,
    output logic [BIAS_W-1:0] bias_wr_data,
    output logic              bias_wr_addr_rst,
    output logic              wt_wr_en,
    output logic [WT_W-1:0]   wt_wr_data,
    output logic              wt_wr_addr_rst,
    output logic [PIX_W-1:0]  pixel_in,
    output logic              pixel_in_valid,
    output logic              pixel_in_last,
    output logic              go,
    input  logic              conv_done,
    output logic              conv_rst,
    output logic              busy,
    output logic              done
);

    typedef enum logic [3:0] {
        IDLE, B_RST, BIAS, W_RST, WT, GO, PIX, WAIT, FLUSH, CRST, FIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] n_bias_q;
    logic [CNT_W-1:0] n_wt_q;
    logic [CNT_W-1:0] n_pix_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] flush_prod;
    logic [CNT_W-1:0] flush_len;
    logic             acc;

    assign acc     = s_valid && s_ready;
    assign cnt_nxt = cnt + CNT_W'(1);

    // Flush length 2*W*(C/8)+4, wrapped to the counter width.
    assign flush_prod = CNT_W'(cfg_img_width) * CNT_W'(cfg_in_channels >> 3);
    assign flush_len  = (flush_prod << 1) + CNT_W'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            n_bias_q         <= '0;
            n_wt_q           <= '0;
            n_pix_q          <= '0;
            flush_q          <= '0;
            s_ready          <= 1'b0;
            bias_wr_en       <= 1'b0;
            bias_wr_data     <= '0;
            bias_wr_addr_rst <= 1'b0;
            wt_wr_en         <= 1'b0;
            wt_wr_data       <= '0;
            wt_wr_addr_rst   <= 1'b0;
            pixel_in         <= '0;
            pixel_in_valid   <= 1'b0;
            pixel_in_last    <= 1'b0;
            go               <= 1'b0;
            conv_rst         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            // Pulse-type outputs default low every cycle.
            bias_wr_en       <= 1'b0;
            bias_wr_addr_rst <= 1'b0;
            wt_wr_en         <= 1'b0;
            wt_wr_addr_rst   <= 1'b0;
            pixel_in_valid   <= 1'b0;
            pixel_in_last    <= 1'b0;
            go               <= 1'b0;
            done             <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        n_bias_q <= cfg_n_bias;
                        n_wt_q   <= cfg_n_wt;
                        n_pix_q  <= cfg_n_pix;
                        flush_q  <= flush_len;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        if (cfg_n_bias != '0) begin
                            state            <= B_RST;
                            bias_wr_addr_rst <= 1'b1;
                        end else begin
                            state          <= W_RST;
                            wt_wr_addr_rst <= 1'b1;
                        end
                    end
                end
                B_RST: begin
                    state   <= BIAS;
                    s_ready <= 1'b1;
                end
                BIAS: begin
                    if (acc) begin
                        bias_wr_en   <= 1'b1;
                        bias_wr_data <= s_data[BIAS_W-1:0];
                        cnt          <= cnt_nxt;
                        if (cnt_nxt == n_bias_q) begin
                            // Drop ready on the final beat so nothing extra is taken.
                            s_ready <= 1'b0;
                            cnt     <= '0;
                            if (n_wt_q != '0) begin
                                state          <= W_RST;
                                wt_wr_addr_rst <= 1'b1;
                            end else begin
                                state <= GO;
                            end
                        end
                    end
                end
                W_RST: begin
                    if (n_wt_q != '0) begin
                        state   <= WT;
                        s_ready <= 1'b1;
                    end else begin
                        state <= GO;
                    end
                end
                WT: begin
                    if (acc) begin
                        wt_wr_en   <= 1'b1;
                        wt_wr_data <= s_data[WT_W-1:0];
                        cnt        <= cnt_nxt;
                        if (cnt_nxt == n_wt_q) begin
                            s_ready <= 1'b0;
                            cnt     <= '0;
                            state   <= GO;
                        end
                    end
                end
                GO: begin
                    go    <= 1'b1;
                    state <= PIX;
                end
                PIX: begin
                    // Ready opens the cycle after the go pulse.
                    if (go) begin
                        s_ready <= 1'b1;
                    end
                    if (acc) begin
                        pixel_in_valid <= 1'b1;
                        pixel_in       <= s_data[PIX_W-1:0];
                        pixel_in_last  <= (cnt_nxt == n_pix_q);
                        cnt            <= cnt_nxt;
                        if (cnt_nxt == n_pix_q) begin
                            s_ready <= 1'b0;
                            cnt     <= '0;
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (conv_done) begin
                        state          <= FLUSH;
                        pixel_in_valid <= 1'b1;
                        pixel_in       <= '0;
                        cnt            <= '0;
                    end
                end
                FLUSH: begin
                    if (cnt_nxt == flush_q) begin
                        state    <= CRST;
                        conv_rst <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        pixel_in_valid <= 1'b1;
                        cnt            <= cnt_nxt;
                    end
                end
                CRST: begin
                    if (cnt_nxt == CNT_W'(CRST_CYCLES)) begin
                        conv_rst <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cnt      <= '0;
                        state    <= FIN;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// tb_conv_stream_feeder: scoreboard bench for conv_stream_feeder.
// Expected write/stream events are queued per pass; a monitor pops them.
module tb_conv_stream_feeder;

    localparam int S_W = 128;
    localparam int BIAS_W = 128;
    localparam int WT_W = 72;
    localparam int PIX_W = 64;
    localparam int CNT_W = 24;
    localparam int CRST_CYCLES = 5;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  cfg_n_bias;
    logic [CNT_W-1:0]  cfg_n_wt;
    logic [CNT_W-1:0]  cfg_n_pix;
    logic [15:0]       cfg_img_width;
    logic [15:0]       cfg_in_channels;
    logic [S_W-1:0]    s_data;
    logic              s_valid;
    logic              s_ready;
    logic              bias_wr_en;
    logic [BIAS_W-1:0] bias_wr_data;
    logic              bias_wr_addr_rst;
    logic              wt_wr_en;
    logic [WT_W-1:0]   wt_wr_data;
    logic              wt_wr_addr_rst;
    logic [PIX_W-1:0]  pixel_in;
    logic              pixel_in_valid;
    logic              pixel_in_last;
    logic              go;
    logic              conv_done;
    logic              conv_rst;
    logic              busy;
    logic              done;

    conv_stream_feeder #(
        .S_W(S_W), .BIAS_W(BIAS_W), .WT_W(WT_W), .PIX_W(PIX_W),
        .CNT_W(CNT_W), .CRST_CYCLES(CRST_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .cfg_n_bias(cfg_n_bias),
        .cfg_n_wt(cfg_n_wt),
        .cfg_n_pix(cfg_n_pix),
        .cfg_img_width(cfg_img_width),
        .cfg_in_channels(cfg_in_channels),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .bias_wr_en(bias_wr_en),
        .bias_wr_data(bias_wr_data),
        .bias_wr_addr_rst(bias_wr_addr_rst),
        .wt_wr_en(wt_wr_en),
        .wt_wr_data(wt_wr_data),
        .wt_wr_addr_rst(wt_wr_addr_rst),
        .pixel_in(pixel_in),
        .pixel_in_valid(pixel_in_valid),
        .pixel_in_last(pixel_in_last),
        .go(go),
        .conv_done(conv_done),
        .conv_rst(conv_rst),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event kinds
    localparam logic [3:0] K_BADDR = 4'd1;
    localparam logic [3:0] K_BWR   = 4'd2;
    localparam logic [3:0] K_WADDR = 4'd3;
    localparam logic [3:0] K_WWR   = 4'd4;
    localparam logic [3:0] K_GO    = 4'd5;
    localparam logic [3:0] K_PIX   = 4'd6;
    localparam logic [3:0] K_LAST  = 4'd7;
    localparam logic [3:0] K_CRST  = 4'd8;
    localparam logic [3:0] K_DONE  = 4'd9;

    typedef struct packed {
        logic [3:0]   k;
        logic [127:0] d;
    } ev_t;

    ev_t exq[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  mcyc = 0;
    int  last_wt_cyc = 0;
    bit  saw_wt = 0;
    bit  chk_rdy = 0;
    int  done_cnt = 0;

    int  idx = 0;
    int  accn = 0;
    bit  acc = 0;
    int  gap_pct = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_ev(input logic [3:0] k, input logic [127:0] d);
        ev_t e;
        n_cmp++;
        if (exq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d data %0h expected none",
                     k, d);
        end else begin
            e = exq.pop_front();
            if (k !== e.k || d !== e.d) begin
                n_bad++;
                $display("FAIL event: got kind %0d data %0h expected kind %0d data %0h",
                         k, d, e.k, e.d);
            end
        end
    endtask

    // Monitor: every notable DUT output is popped against the scoreboard.
    always @(negedge clk) begin
        mcyc++;
        if (rst_n) begin
            if (chk_rdy) begin
                chk_rdy = 0;
                check("s_ready_after_go", 128'(s_ready), 128'(1));
            end
            if (bias_wr_addr_rst) mon_ev(K_BADDR, '0);
            if (bias_wr_en) mon_ev(K_BWR, bias_wr_data);
            if (wt_wr_addr_rst) mon_ev(K_WADDR, '0);
            if (wt_wr_en) begin
                mon_ev(K_WWR, 128'(wt_wr_data));
                last_wt_cyc = mcyc;
                saw_wt = 1;
            end
            if (go) begin
                mon_ev(K_GO, '0);
                if (saw_wt)
                    check("go_after_last_wt", 128'(mcyc - last_wt_cyc), 128'(1));
                saw_wt = 0;
                chk_rdy = 1;
            end
            if (pixel_in_valid)
                mon_ev(pixel_in_last ? K_LAST : K_PIX, 128'(pixel_in));
            if (conv_rst) mon_ev(K_CRST, '0);
            if (done) begin
                mon_ev(K_DONE, '0);
                done_cnt++;
            end
        end
    end

    function automatic logic [127:0] word(input int i);
        logic [31:0] u;
        u = i;
        return {u * 32'd7 + 32'h11, 32'hC0DE0000 ^ u,
                32'h10000000 + u, 32'h80000000 | u};
    endfunction

    task automatic push(input logic [3:0] k, input logic [127:0] d);
        ev_t e;
        e.k = k;
        e.d = d;
        exq.push_back(e);
    endtask

    task automatic push_pass(input int nb, input int nw, input int np,
                             input int w, input int ch);
        logic [127:0] wd;
        int f;
        f = (2 * w * (ch >> 3) + 4) & 32'h00FF_FFFF;
        if (nb > 0) push(K_BADDR, '0);
        for (int i = 0; i < nb; i++) push(K_BWR, word(i));
        if (nb == 0 || nw > 0) push(K_WADDR, '0);
        for (int i = 0; i < nw; i++) begin
            wd = word(nb + i);
            push(K_WWR, {56'd0, wd[71:0]});
        end
        push(K_GO, '0);
        for (int i = 0; i < np; i++) begin
            wd = word(nb + nw + i);
            push((i == np - 1) ? K_LAST : K_PIX, {64'd0, wd[63:0]});
        end
        for (int i = 0; i < f; i++) push(K_PIX, '0);
        for (int i = 0; i < CRST_CYCLES; i++) push(K_CRST, '0);
        push(K_DONE, '0);
    endtask

    // One clock of upstream source: advance past a consumed word, redrive.
    task automatic cyc();
        @(negedge clk);
        if (acc) begin
            idx++;
            accn++;
        end
        s_valid = ($urandom_range(99) >= gap_pct);
        s_data = word(idx);
        acc = s_valid && s_ready;
    endtask

    task automatic run_pass(input int nb, input int nw, input int np,
                            input int w, input int ch, input int gp,
                            input bit inj, input bit rst_mid);
        bit seen;
        bit inj_s;
        bit inj_d;
        int wtn;
        int done0;
        push_pass(nb, nw, np, w, ch);
        gap_pct = gp;
        cfg_n_bias = nb;
        cfg_n_wt = nw;
        cfg_n_pix = np;
        cfg_img_width = w;
        cfg_in_channels = ch;
        idx = 0;
        accn = 0;
        done0 = done_cnt;
        cyc();
        start = 1;
        cyc();
        start = 0;
        // Scramble cfg to prove it was latched.
        cfg_n_bias = 7;
        cfg_n_wt = 3;
        cfg_n_pix = 5;
        cfg_img_width = 1;
        cfg_in_channels = 64;
        check("busy_after_start", 128'(busy), 128'(1));
        check("bias_addr_rst_after_start", 128'(bias_wr_addr_rst), 128'(nb > 0));
        check("wt_addr_rst_after_start", 128'(wt_wr_addr_rst), 128'(nb == 0));
        seen = 0;
        inj_s = 0;
        inj_d = 0;
        wtn = 0;
        for (int t = 0; t < 20000 && !seen; t++) begin
            cyc();
            conv_done = 0;
            start = 0;
            if (wt_wr_en) wtn++;
            if (inj && !inj_d && wt_wr_en) begin
                conv_done = 1;
                inj_d = 1;
            end
            if (inj && !inj_s && pixel_in_valid) begin
                start = 1;
                inj_s = 1;
            end
            if (rst_mid && wtn == 10) begin
                #2 rst_n = 0;
                #1;
                check("abort_s_ready", 128'(s_ready), 128'(0));
                check("abort_busy", 128'(busy), 128'(0));
                check("abort_wt_wr_en", 128'(wt_wr_en), 128'(0));
                check("abort_wt_wr_data", 128'(wt_wr_data), 128'(0));
                check("abort_conv_rst", 128'(conv_rst), 128'(0));
                exq.delete();
                acc = 0;
                idx = 0;
                saw_wt = 0;
                cyc();
                #2 rst_n = 1;
                repeat (30) cyc();
                check("no_done_after_abort", 128'(done_cnt - done0), 128'(0));
                check("idle_after_abort", 128'(busy), 128'(0));
                return;
            end
            if (pixel_in_valid && pixel_in_last) seen = 1;
        end
        start = 0;
        conv_done = 0;
        check("pix_last_seen", 128'(seen), 128'(1));
        repeat (3) cyc();
        conv_done = 1;
        cyc();
        conv_done = 0;
        seen = 0;
        for (int t = 0; t < 5000 && !seen; t++) begin
            cyc();
            if (done) begin
                seen = 1;
                check("busy_falls_with_done", 128'(busy), 128'(0));
            end
        end
        check("done_seen", 128'(seen), 128'(1));
        repeat (3) cyc();
        check("upstream_beats_consumed", 128'(accn), 128'(nb + nw + np));
        check("done_pulses", 128'(done_cnt - done0), 128'(1));
        check("scoreboard_drained", 128'(exq.size()), 128'(0));
    endtask

    initial begin
        rst_n = 0;
        start = 0;
        conv_done = 0;
        s_valid = 0;
        s_data = '0;
        cfg_n_bias = '0;
        cfg_n_wt = '0;
        cfg_n_pix = '0;
        cfg_img_width = '0;
        cfg_in_channels = '0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 128'(s_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_go", 128'(go), 128'(0));
        check("rst_conv_rst", 128'(conv_rst), 128'(0));
        check("rst_bias_wr_en", 128'(bias_wr_en), 128'(0));
        check("rst_bias_wr_data", bias_wr_data, 128'(0));
        check("rst_wt_wr_data", 128'(wt_wr_data), 128'(0));
        check("rst_pixel_in", 128'(pixel_in), 128'(0));
        check("rst_pixel_in_valid", 128'(pixel_in_valid), 128'(0));
        rst_n = 1;
        run_pass(4, 64, 100, 10, 8, 0, 0, 0);
        run_pass(0, 64, 20, 10, 8, 0, 0, 0);
        run_pass(3, 16, 60, 10, 8, 30, 0, 0);
        run_pass(4, 64, 100, 10, 8, 0, 1, 0);
        run_pass(4, 64, 100, 10, 8, 0, 0, 1);
        run_pass(2, 8, 10, 10, 8, 0, 0, 0);
        run_pass(2, 8, 10, 418, 16, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
